// File: rtl/hamming_serial_encoder_p.sv
// ---------------------------------------------------------------------------
// hamming_serial_encoder_p
//
// Serial-in / serial-out Hamming encoder for the link transmit path.
// K data bits are collected from s_in, R Hamming parity bits (plus an
// optional overall even-parity bit) are appended, and the W-bit codeword
// is shifted out on s_out under a valid/ready handshake. A one-deep
// pending buffer decouples collection from transmission, so the input
// side never stalls.
//
// Parameters
//   R          : Hamming parity bits (3..6); N = 2^R-1, K = N-R
//   EXT_PARITY : 1 appends an overall even-parity bit, W = N + EXT_PARITY
//   MSB_FIRST  : 0 sends position 1 first (extended bit last);
//                1 sends the extended bit first, then position N down to 1
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   s_in         in   serial data bit
//   s_in_valid   in   s_in is sampled on the edge while high
//   s_out        out  serial codeword bit
//   s_out_valid  out  s_out holds a codeword bit
//   s_out_ready  in   downstream accepts s_out when valid and ready are high
//   frame_start  out  high with the first bit of each codeword
//   busy         out  shifter or pending buffer holds a word
//   overrun      out  one-cycle pulse when a completed word is dropped
//   dbg_state_o  out  output FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a bit transfers on every rising edge where s_out_valid and
// s_out_ready are both high; s_out_valid never drops while a word is in
// flight and s_out holds its value while s_out_ready is low.
// ---------------------------------------------------------------------------
module hamming_serial_encoder_p #(
    parameter int R          = 4,
    parameter int EXT_PARITY = 0,
    parameter int MSB_FIRST  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic s_in,
    input  logic s_in_valid,
    output logic s_out,
    output logic s_out_valid,
    input  logic s_out_ready,
    output logic frame_start,
    output logic busy,
    output logic overrun,
    output logic dbg_state_o
);

    localparam int N  = (1 << R) - 1;
    localparam int K  = N - R;
    localparam int W  = N + EXT_PARITY;
    localparam int CW = $clog2(K);
    localparam int IW = $clog2(W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [K-1:0]    data_q, data_d;
    logic [W-1:0]    pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            overrun_q, overrun_d;

    logic            word_done;
    logic            hs;
    logic            last_bit;
    logic            load;
    logic [K-1:0]    data_full;
    logic [W-1:0]    code_word;

    // Builds the codeword already arranged in transmit order: bit 0 of the
    // result is the first bit on the wire, so the shifter only shifts right.
    function automatic logic [W-1:0] encode(input logic [K-1:0] d);
        logic [N:1]   cw;
        logic [W-1:0] tx;
        logic         par;
        logic         ext;
        int           di;
        cw = '0;
        tx = '0;
        di = 0;
        // Data bits fill the non-power-of-two positions in ascending order.
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[di];
                di++;
            end
        end
        // Parity positions are still zero here, so they do not disturb the sums.
        for (int j = 0; j < R; j++) begin
            par = 1'b0;
            for (int p = 1; p <= N; p++) begin
                if (((p >> j) & 1) != 0) par = par ^ cw[p];
            end
            cw[1 << j] = par;
        end
        ext = ^cw;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < N; i++) tx[i] = cw[i + 1];
            if (EXT_PARITY != 0) tx[W-1] = ext;
        end else begin
            if (EXT_PARITY != 0) tx[0] = ext;
            for (int i = 0; i < N; i++) tx[i + EXT_PARITY] = cw[N - i];
        end
        return tx;
    endfunction

    // ---------------- shared combinational terms ----------------
    assign word_done = s_in_valid && (cnt_q == CW'(K - 1));
    assign hs        = (state_q == SHIFT) && s_out_ready;
    assign last_bit  = (idx_q == IW'(W - 1));
    // Pending word moves to the shifter from IDLE, or back-to-back on the
    // handshake of the last bit of the current word.
    assign load      = pend_full_q && ((state_q == IDLE) || (hs && last_bit));

    always_comb begin
        data_full        = data_q;
        data_full[K-1]   = s_in;
    end

    assign code_word = encode(data_full);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_full_q) state_d = SHIFT;
            SHIFT:   if (hs && last_bit && !pend_full_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_out_valid = (state_q == SHIFT);
        s_out       = s_out_valid & shift_q[0];
        frame_start = s_out_valid && (idx_q == '0);
        busy        = pend_full_q || (state_q == SHIFT);
        overrun     = overrun_q;
        dbg_state_o = (state_q == SHIFT);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d       = cnt_q;
        data_d      = data_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        overrun_d   = 1'b0;

        if (s_in_valid) begin
            data_d[cnt_q] = s_in;
            cnt_d         = word_done ? '0 : cnt_q + CW'(1);
        end

        if (load) begin
            shift_d     = pend_q;
            idx_d       = '0;
            pend_full_d = 1'b0;
        end else if (hs) begin
            shift_d = shift_q >> 1;
            idx_d   = last_bit ? '0 : idx_q + IW'(1);
        end

        // A freshly completed word may take the buffer if it is empty or is
        // being emptied on this same edge; otherwise it is dropped.
        if (word_done) begin
            if (!pend_full_q || load) begin
                pend_d      = code_word;
                pend_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            data_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: doc/hamming_serial_encoder_p.md
Name: hamming_serial_encoder_p

Overview:
- Parametrised serial-in/serial-out Hamming encoder for the link transmit path.
- Deserialises K data bits, appends R Hamming parity bits and an optional overall parity bit (SECDED), then serialises the codeword.
- Single clock domain; output path has a valid/ready handshake and a one-deep pending buffer, so input collection never waits on the output.

Parameters:
- R, 4, number of Hamming parity bits; N = 2^R - 1 codeword bits, K = N - R data bits; legal range 3..6.
- EXT_PARITY, 0, 1 appends an overall even-parity bit; output word length W = N + EXT_PARITY.
- MSB_FIRST, 0, 0 sends position 1 first (extended bit last); 1 sends the extended bit first, then position N down to 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- s_in  in  1  serial data bit.
- s_in_valid  in  1  s_in is sampled on the clock edge while high.
- s_out  out  1  serial codeword bit.
- s_out_valid  out  1  s_out holds a codeword bit.
- s_out_ready  in  1  downstream accepts s_out on the edge when s_out_valid and s_out_ready are both high.
- frame_start  out  1  high with the first bit of each codeword.
- busy  out  1  the shifter or the pending buffer holds a word.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, data shift register, bit counter, pending buffer and shifter cleared, state IDLE. A partially collected word is discarded. Operation resumes on the first edge after reset is released.
- Input path:
  - Bit counter runs 0..K-1 and advances only on edges with s_in_valid high.
  - The first received bit is data bit d0.
  - On the edge that samples d(K-1), the counter wraps to 0 and the encoded word is written to the pending buffer (pend_full <= 1).
- Encoding (combinational from the collected data plus the incoming last bit):
  - Positions 1..N; parity bit p_j sits at position 2^j.
  - Data d0..d(K-1) fill the non-power-of-two positions in ascending order.
  - p_j = XOR of every position whose index has bit j set.
  - Extended bit = XOR of positions 1..N.
- Output FSM:
  - IDLE: s_out_valid=0. If pend_full, load the shifter from the pending buffer, clear pend_full, go to SHIFT.
  - SHIFT: s_out_valid=1. On each handshake the shifter advances and the bit index increments.
    - On the handshake of bit W-1: if pend_full, reload from pending in the same edge (back-to-back, no idle cycle); else go to IDLE.
    - If s_out_ready is low, s_out and the index hold.
- Latency: with s_out_ready=1 and the output idle, the first codeword bit is valid in the 2nd cycle after the edge that samples d(K-1).
- frame_start = s_out_valid and (bit index == 0).
- busy = pend_full or (state == SHIFT).
- Overrun: the word completes while pend_full=1 and the pending buffer is not being transferred on that edge. Then the new word is dropped, pending keeps the older word, and overrun pulses for 1 cycle.
  - Completion on the same edge as a pending-to-shifter transfer is not an overrun; the new word is written.
- Input collection is never stalled, and s_in_valid gaps of any length are tolerated.
- Reset mid-frame: the shifter is abandoned, s_out_valid drops immediately, and no partial codeword is resumed.

Test Plan:
- R=4, EXT=0, ready=1, 11 zero bits -> 15 zeros out; frame_start on the first bit only; first bit valid 2 cycles after the last input edge.
- R=4, EXT=0, d0=1 and others 0 -> output sequence 1,1,1 followed by twelve 0s. Same data with EXT=1 -> 16th bit = 1. With MSB_FIRST=1 and EXT=1 -> extended bit 1 first, then twelve 0s, then 1,1,1.
- R=4, EXT=1, 11 ones -> 16 ones out. R=3 (K=4), data 1,0,1,1 -> codeword positions 1..7 = 0,1,1,0,0,1,1.
- s_out_ready held low while 3 words are fed -> word1 in the shifter and word2 pending; overrun pulses once at word3 completion. Releasing ready then gives exactly word1 followed by word2, back-to-back with no gap.
- Random s_in_valid and s_out_ready gaps over 200 words with a reference model -> all codewords match and no overrun when the average ready rate ≥ W/K of the input rate.
- Reset asserted after 6 input bits and again mid-SHIFT -> outputs 0 immediately; the next 11 bits form a clean word with the correct codeword.
